// File: rtl/mem_access.sv
// Memory stage: issues loads/stores on a req/gnt/rvalid bus, stalls upstream while busy, registers MEM/WB.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN (aborts after TIMEOUT_CYCLES, pulses buserr_o).
module mem_access #(
  parameter logic [7:0]  OP_LB          = 8'hE0,
  parameter logic [7:0]  OP_LH          = 8'hE1,
  parameter logic [7:0]  OP_LW          = 8'hE2,
  parameter logic [7:0]  OP_LBU         = 8'hE3,
  parameter logic [7:0]  OP_LHU         = 8'hE4,
  parameter logic [7:0]  OP_SB          = 8'hE8,
  parameter logic [7:0]  OP_SH          = 8'hE9,
  parameter logic [7:0]  OP_SW          = 8'hEA,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        buserr_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] bwdata_q, bwdata_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] ld_q, ld_d;
  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        misalign_q, misalign_d;
  logic        abort_q, abort_d;
  logic        timeout;

  logic        is_load, is_store, is_mem, sz_b, sz_h, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] st_data;

  function automatic logic [31:0] extract(input logic [7:0] op, input logic [1:0] off,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    if (op == OP_LB)       extract = {{24{b[7]}}, b};
    else if (op == OP_LBU) extract = {24'h0, b};
    else if (op == OP_LH)  extract = {{16{h[15]}}, h};
    else if (op == OP_LHU) extract = {16'h0, h};
    else                   extract = d;
  endfunction

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_b     = 1'b0;
    sz_h     = 1'b0;
    case (aluop_i)
      OP_LB, OP_LBU: begin is_load = 1'b1;  sz_b = 1'b1; end
      OP_LH, OP_LHU: begin is_load = 1'b1;  sz_h = 1'b1; end
      OP_LW:         is_load = 1'b1;
      OP_SB:         begin is_store = 1'b1; sz_b = 1'b1; end
      OP_SH:         begin is_store = 1'b1; sz_h = 1'b1; end
      OP_SW:         is_store = 1'b1;
      default:       ;
    endcase
    is_mem     = is_load | is_store;
    misaligned = (sz_h & mem_addr_i[0]) | (~sz_b & ~sz_h & (mem_addr_i[1:0] != 2'b00));
    if (sz_b) begin
      be_calc = 4'b0001 << mem_addr_i[1:0];
      st_data = {4{reg2_i[7:0]}};
    end else if (sz_h) begin
      be_calc = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      st_data = {2{reg2_i[15:0]}};
    end else begin
      be_calc = 4'hF;
      st_data = reg2_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    bwdata_d   = bwdata_q;
    op_d       = op_q;
    off_d      = off_q;
    ld_d       = ld_q;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    misalign_d = 1'b0;
    abort_d    = 1'b0;
    stallreq_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!is_mem) begin
          wd_d    = wd_i;
          wreg_d  = wreg_i;
          wdata_d = wdata_i;
        end else if (misaligned) begin
          wreg_d     = 1'b0;
          misalign_d = 1'b1;
        end else begin
          stallreq_o = 1'b1;
          wreg_d     = 1'b0;
          addr_d     = {mem_addr_i[31:2], 2'b00};
          we_d       = is_store;
          be_d       = be_calc;
          bwdata_d   = st_data;
          op_d       = aluop_i;
          off_d      = mem_addr_i[1:0];
          state_d    = REQ;
        end
      end
      REQ: begin
        stallreq_o = 1'b1;
        wreg_d     = 1'b0;
        if (mem_gnt_i) begin
          if (we_q) begin
            state_d = DONE;
          end else if (mem_rvalid_i) begin
            ld_d    = extract(op_q, off_q, mem_rdata_i);
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else if (timeout) begin
          abort_d = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        stallreq_o = 1'b1;
        wreg_d     = 1'b0;
        if (mem_rvalid_i) begin
          ld_d    = extract(op_q, off_q, mem_rdata_i);
          state_d = DONE;
        end else if (timeout) begin
          abort_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        wreg_d  = 1'b0;
        state_d = IDLE;
        if (!we_q && !abort_q) begin
          wd_d    = wd_i;
          wreg_d  = 1'b1;
          wdata_d = ld_q;
        end
      end
    endcase
    // An idle decode must not request a stall while reset holds the stage.
    if (!rst) stallreq_o = 1'b0;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero while idle so every access starts counting from its first REQ cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)                          cnt_d = '0;
    else if (state_q == REQ || state_q == WAIT)   cnt_d = cnt_q + 1'b1;
  end

  assign timeout  = (state_q == REQ || state_q == WAIT) && (cnt_d >= CNT_W'(TIMEOUT_CYCLES));
  assign buserr_o = abort_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout  = 1'b0;
  assign buserr_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      bwdata_q   <= '0;
      op_q       <= '0;
      off_q      <= '0;
      ld_q       <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      bwdata_q   <= bwdata_d;
      op_q       <= op_d;
      off_q      <= off_d;
      ld_q       <= ld_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
      abort_q    <= abort_d;
    end
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = bwdata_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign misalign_o  = misalign_q;

endmodule
